// File: rtl/operand_entry.sv
// operand_entry
//   Key-sequence parser behind the keypad encoder. Assembles decimal digit
//   presses into two binary operands plus an add/subtract operator, and on
//   Enter offers one command to the arithmetic datapath over valid/ready.
//
//   Ports
//     clk            system clock, rising edge
//     nrst           asynchronous active-low reset
//     keycode[3:0]   0-9 digit, 10 add, 11 subtract, 12 enter, 15 multi-press
//     keystrobe      level strobe, high while a key is held
//     operand_a      first operand of the issued command
//     operand_b      second operand of the issued command
//     op_sub         operator, 0 = add, 1 = subtract
//     cmd_valid      command available
//     cmd_ready      datapath accepts the command
//     display_value  value being typed (operand_b while a command is pending)
//     stage[1:0]     0 ENTER_A, 1 ENTER_B, 2 ISSUE
//     error          one-cycle pulse for a rejected key
module operand_entry #(
   parameter int DIGITS = 3,
   parameter int WIDTH  = 10
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [3:0]       keycode,
   input  logic             keystrobe,
   output logic [WIDTH-1:0] operand_a,
   output logic [WIDTH-1:0] operand_b,
   output logic             op_sub,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [WIDTH-1:0] display_value,
   output logic [1:0]       stage,
   output logic             error
);

   localparam int                CNT_W   = $clog2(DIGITS + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIGITS);
   localparam logic [3:0]        KEY_ADD = 4'd10;
   localparam logic [3:0]        KEY_SUB = 4'd11;
   localparam logic [3:0]        KEY_ENT = 4'd12;

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      ISSUE   = 2'd2
   } state_t;

   state_t           state_q;
   logic             strobe_q;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] cnt;

   logic             key_hit;
   logic             is_digit;
   logic             is_op;
   logic [WIDTH-1:0] acc_dig;

   // A held key is seen once: only the low-to-high transition of the strobe
   // counts, and the history register keeps tracking even while a command
   // is pending so a key held across the return to ENTER_A is not re-taken.
   assign key_hit  = keystrobe & ~strobe_q;
   assign is_digit = (keycode <= 4'd9);
   assign is_op    = (keycode == KEY_ADD) || (keycode == KEY_SUB);

   // Only used while cnt < DIGITS, so acc < 10^(DIGITS-1) and the result
   // always fits in WIDTH bits.
   assign acc_dig  = acc * WIDTH'(10) + WIDTH'(keycode);

   assign stage    = state_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q       <= ENTER_A;
         strobe_q      <= 1'b0;
         acc           <= '0;
         cnt           <= '0;
         operand_a     <= '0;
         operand_b     <= '0;
         op_sub        <= 1'b0;
         cmd_valid     <= 1'b0;
         display_value <= '0;
         error         <= 1'b0;
      end else begin
         strobe_q <= keystrobe;
         error    <= 1'b0;

         case (state_q)
            ISSUE: begin
               // Any key while a command is pending is dropped; a handshake
               // on the same edge still completes.
               if (key_hit) begin
                  error <= 1'b1;
               end
               if (cmd_valid && cmd_ready) begin
                  cmd_valid     <= 1'b0;
                  acc           <= '0;
                  cnt           <= '0;
                  display_value <= '0;
                  state_q       <= ENTER_A;
               end
            end

            ENTER_A, ENTER_B: begin
               if (key_hit) begin
                  if (is_digit) begin
                     if (cnt < CNT_MAX) begin
                        acc           <= acc_dig;
                        cnt           <= cnt + CNT_W'(1);
                        display_value <= acc_dig;
                     end else begin
                        error <= 1'b1;
                     end
                  end else if (is_op) begin
                     if (state_q == ENTER_A) begin
                        if (cnt != '0) begin
                           operand_a     <= acc;
                           op_sub        <= (keycode == KEY_SUB);
                           acc           <= '0;
                           cnt           <= '0;
                           display_value <= '0;
                           state_q       <= ENTER_B;
                        end else begin
                           error <= 1'b1;
                        end
                     end else begin
                        // Before any digit of B the operator may be corrected.
                        if (cnt == '0) begin
                           op_sub <= (keycode == KEY_SUB);
                        end else begin
                           error <= 1'b1;
                        end
                     end
                  end else if (keycode == KEY_ENT) begin
                     if ((state_q == ENTER_B) && (cnt != '0)) begin
                        operand_b     <= acc;
                        display_value <= acc;
                        cmd_valid     <= 1'b1;
                        state_q       <= ISSUE;
                     end else begin
                        error <= 1'b1;
                     end
                  end else begin
                     // 13, 14 unused and 15 multi-press
                     error <= 1'b1;
                  end
               end
            end

            default: begin
               state_q <= ENTER_A;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_operand_entry.sv
module tb_operand_entry;

   localparam int DIGITS = 3;
   localparam int WIDTH  = 10;

   logic             tb_clk;
   logic             nrst;
   logic [3:0]       keycode;
   logic             keystrobe;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             op_sub;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] display_value;
   logic [1:0]       stage;
   logic             error;

   int checks;
   int errors;
   int err_cnt;
   int valid_cnt;
   int e0;
   int v0;

   operand_entry #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
      .clk           (tb_clk),
      .nrst          (nrst),
      .keycode       (keycode),
      .keystrobe     (keystrobe),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .op_sub        (op_sub),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .display_value (display_value),
      .stage         (stage),
      .error         (error)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   // Count high cycles of the error pulse and of cmd_valid.
   always @(negedge tb_clk) begin
      if (error === 1'b1)     err_cnt++;
      if (cmd_valid === 1'b1) valid_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present a key for 'hold' cycles, release for 'idle' cycles, then settle
   // 1 time unit past the falling edge so the monitor has already run.
   task automatic press(input logic [3:0] code, input int hold, input int idle);
      @(negedge tb_clk);
      keycode   = code;
      keystrobe = 1'b1;
      repeat (hold) @(negedge tb_clk);
      keystrobe = 1'b0;
      repeat (idle) @(negedge tb_clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge tb_clk);
      nrst      = 1'b0;
      keystrobe = 1'b0;
      repeat (2) @(negedge tb_clk);
      nrst = 1'b1;
      #1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      err_cnt   = 0;
      valid_cnt = 0;
      nrst      = 1'b0;
      keycode   = 4'd0;
      keystrobe = 1'b0;
      cmd_ready = 1'b1;

      // Reset state
      #12;
      check("rst_stage",     stage,         0);
      check("rst_valid",     cmd_valid,     0);
      check("rst_error",     error,         0);
      check("rst_opa",       operand_a,     0);
      check("rst_opb",       operand_b,     0);
      check("rst_sub",       op_sub,        0);
      check("rst_disp",      display_value, 0);
      @(negedge tb_clk);
      nrst = 1'b1;

      // Basic command 12 + 34
      e0 = err_cnt;
      v0 = valid_cnt;
      press(4'd1, 3, 2);
      check("basic_disp1", display_value, 1);
      press(4'd2, 3, 2);
      check("basic_disp12", display_value, 12);
      press(4'd10, 3, 2);
      check("basic_stageB", stage, 1);
      press(4'd3, 3, 2);
      press(4'd4, 3, 2);
      check("basic_disp34", display_value, 34);
      press(4'd12, 3, 2);
      check("basic_opa",    operand_a, 12);
      check("basic_sub",    op_sub,    0);
      check("basic_opb",    operand_b, 34);
      check("basic_vcyc",   valid_cnt - v0, 1);
      check("basic_stage",  stage, 0);
      check("basic_disp0",  display_value, 0);
      check("basic_noerr",  err_cnt - e0, 0);

      // Held key and digit limit
      e0 = err_cnt;
      press(4'd9, 10, 2);
      check("held_disp9", display_value, 9);
      press(4'd8, 3, 2);
      press(4'd7, 3, 2);
      check("lim_noerr_yet", err_cnt - e0, 0);
      press(4'd6, 3, 2);
      check("lim_disp987", display_value, 987);
      check("lim_err_once", err_cnt - e0, 1);

      // Sequence errors
      do_reset();
      e0 = err_cnt;
      press(4'd12, 2, 2);
      check("seq_ent_err",   err_cnt - e0, 1);
      check("seq_ent_stage", stage, 0);
      e0 = err_cnt;
      press(4'd5,  2, 2);
      press(4'd11, 2, 2);
      check("seq_sub1", op_sub, 1);
      press(4'd10, 2, 2);
      check("seq_sub0",    op_sub, 0);
      check("seq_corr_ok", err_cnt - e0, 0);
      check("seq_stageB",  stage, 1);
      e0 = err_cnt;
      press(4'd12, 2, 2);
      check("seq_entB_err",   err_cnt - e0, 1);
      check("seq_entB_stage", stage, 1);
      press(4'd7,  2, 2);
      press(4'd12, 2, 2);
      check("seq_opa5", operand_a, 5);
      check("seq_opb7", operand_b, 7);

      // Invalid and multi-press codes in ENTER_B with value 4
      do_reset();
      press(4'd1,  2, 2);
      press(4'd10, 2, 2);
      press(4'd4,  2, 2);
      e0 = err_cnt;
      press(4'd15, 2, 2);
      check("inv15_err",  err_cnt - e0, 1);
      check("inv15_disp", display_value, 4);
      e0 = err_cnt;
      press(4'd13, 2, 2);
      check("inv13_err",   err_cnt - e0, 1);
      check("inv13_disp",  display_value, 4);
      check("inv13_stage", stage, 1);

      // Backpressure: 100 - 1 held pending
      do_reset();
      cmd_ready = 1'b0;
      press(4'd1,  2, 2);
      press(4'd0,  2, 2);
      press(4'd0,  2, 2);
      press(4'd11, 2, 2);
      press(4'd1,  2, 2);
      press(4'd12, 2, 2);
      check("bp_stage2", stage, 2);
      e0 = err_cnt;
      press(4'd3, 2, 3);
      check("bp_valid", cmd_valid, 1);
      check("bp_opa",   operand_a, 100);
      check("bp_opb",   operand_b, 1);
      check("bp_sub",   op_sub, 1);
      check("bp_disp",  display_value, 1);
      check("bp_err",   err_cnt - e0, 1);
      @(negedge tb_clk);
      cmd_ready = 1'b1;
      @(negedge tb_clk);
      #1;
      check("bp_ret_stage", stage, 0);
      check("bp_ret_valid", cmd_valid, 0);
      check("bp_ret_disp",  display_value, 0);

      // Reset while a command is pending
      cmd_ready = 1'b0;
      press(4'd2,  2, 2);
      press(4'd10, 2, 2);
      press(4'd3,  2, 2);
      press(4'd12, 2, 2);
      check("ri_valid_pre", cmd_valid, 1);
      @(negedge tb_clk);
      #2;
      nrst = 1'b0;
      keycode   = 4'd5;
      keystrobe = 1'b1;
      #1;
      check("ri_valid", cmd_valid, 0);
      check("ri_opa",   operand_a, 0);
      check("ri_opb",   operand_b, 0);
      check("ri_stage", stage, 0);
      check("ri_disp",  display_value, 0);

      // Strobe already high at reset release counts as a fresh press
      @(negedge tb_clk);
      nrst = 1'b1;
      @(negedge tb_clk);
      #1;
      check("fresh_disp5", display_value, 5);
      keystrobe = 1'b0;
      repeat (2) @(negedge tb_clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
